// File: rtl/apb_slv_pkg.sv
// Shared types and defaults for the APB register-file completer.
package apb_slv_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int AW_DEF          = 8;
    localparam int DW_DEF          = 8;
    localparam int DEPTH_DEF       = 64;
    localparam int WAIT_STATES_DEF = 2;
    localparam int WCNT_W          = 4;

endpackage

// File: rtl/apb_slv_mem_array.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module apb_slv_mem_array #(
    parameter int DW    = 8,
    parameter int DEPTH = 64,
    parameter int AIW   = 6
) (
    input  logic           pclk,
    input  logic           we,
    input  logic [AIW-1:0] waddr,
    input  logic [DW-1:0]  wdata,
    input  logic [AIW-1:0] raddr,
    output logic [DW-1:0]  rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a register file, with programmable wait states and range errors.
// Optional protocol checker enabled by defining APB_SLV_PROT_CHK_EN.
module apb_slave_mem
    import apb_slv_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr,
    output logic          prot_err
);

    localparam int                AIW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WCNT_W-1:0] WAIT_L  = WCNT_W'(WAIT_STATES);
    localparam logic [AW:0]       DEPTH_L = (AW+1)'(DEPTH);

    apb_state_e        state, state_d;
    logic [WCNT_W-1:0] wcnt, wcnt_d;
    logic [AW-1:0]     addr_q;
    logic              wr_q;
    logic [DW-1:0]     wdata_q;
    logic              capture;
    logic              mem_we;
    logic              in_range;
    logic [DW-1:0]     rdata;

    assign in_range = ({1'b0, addr_q} < DEPTH_L);

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state   <= IDLE;
            wcnt    <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_d;
            wcnt  <= wcnt_d;
            if (capture) begin
                addr_q  <= paddr;
                wr_q    <= pwrite;
                wdata_q <= pwdata;
            end
        end
    end

    // A reset arriving in the final access cycle suppresses both pready and the commit.
    always_comb begin
        state_d = state;
        wcnt_d  = wcnt;
        capture = 1'b0;
        pready  = 1'b0;
        mem_we  = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    wcnt_d  = '0;
                    capture = 1'b1;
                end
            end
            ACCESS: begin
                if (psel && penable) begin
                    if (wcnt == WAIT_L) begin
                        pready  = presetn;
                        mem_we  = presetn && wr_q && in_range;
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pslverr = pready && !in_range;
    assign prdata  = (pready && !wr_q && in_range) ? rdata : '0;

    apb_slv_mem_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AIW   (AIW)
    ) u_mem (
        .pclk  (pclk),
        .we    (mem_we),
        .waddr (addr_q[AIW-1:0]),
        .wdata (wdata_q),
        .raddr (addr_q[AIW-1:0]),
        .rdata (rdata)
    );

`ifdef APB_SLV_PROT_CHK_EN
    logic prot_err_q;
    logic prot_viol;

    // penable is shared across slaves, so only violations seen while selected count.
    always_comb begin
        prot_viol = 1'b0;
        if (state == IDLE) begin
            prot_viol = psel && penable;
        end else begin
            prot_viol = !psel || (paddr != addr_q) || (pwrite != wr_q) ||
                        (pwdata != wdata_q);
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            prot_err_q <= 1'b0;
        end else if (prot_viol) begin
            prot_err_q <= 1'b1;
        end
    end

    assign prot_err = prot_err_q;
`else
    assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: two instances (2 and 0 wait states) on one shared APB bus.
module tb_apb_slave_mem;

    logic       pclk;
    logic       presetn;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    bit         which;

    logic       psel_a, psel_b;
    logic [7:0] prdata_a, prdata_b, prdata;
    logic       pready_a, pready_b, pready;
    logic       pslverr_a, pslverr_b, pslverr;
    logic       prot_a, prot_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [2][64];

    typedef struct {
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        bit         b2b;
        logic [7:0] exp_rd;
        bit         exp_err;
    } vec_t;

    vec_t vecs [8];

    assign psel_a  = psel && !which;
    assign psel_b  = psel && which;
    assign prdata  = which ? prdata_b  : prdata_a;
    assign pready  = which ? pready_b  : pready_a;
    assign pslverr = which ? pslverr_b : pslverr_a;

    apb_slave_mem #(.AW(8), .DW(8), .DEPTH(64), .WAIT_STATES(2)) dut_a (
        .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a),
        .pready(pready_a), .pslverr(pslverr_a), .prot_err(prot_a)
    );

    apb_slave_mem #(.AW(8), .DW(8), .DEPTH(64), .WAIT_STATES(0)) dut_b (
        .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b),
        .pready(pready_b), .pslverr(pslverr_b), .prot_err(prot_b)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
    endtask

    // One APB transfer; with b2b set the caller must start the next setup immediately.
    task automatic applyStimulus(input bit w, input logic [7:0] a, input logic [7:0] d,
                                 input bit b2b, output logic [7:0] rd, output bit err,
                                 output int n_acc);
        n_acc = 0;
        rd    = '0;
        err   = 1'b0;
        @(posedge pclk);
        #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(negedge pclk);
        checkOutput("setup_outs", {pready, pslverr, prdata}, 32'h0);
        @(posedge pclk);
        #1 penable = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge pclk);
            if (pready) begin
                n_acc = n;
                rd    = prdata;
                err   = pslverr;
                break;
            end
            checkOutput("wait_outs", {pslverr, prdata}, 32'h0);
            @(posedge pclk);
            #1;
        end
        if (!b2b) begin
            @(posedge pclk);
            #1 psel = 1'b0; penable = 1'b0;
        end
    endtask

    task automatic doCheckedXfer(input bit w, input logic [7:0] a, input logic [7:0] d,
                                 input bit b2b, input string tag);
        logic [7:0] exp_rd, rd;
        bit         exp_err, err;
        int         n_acc;
        exp_err = (a >= 8'd64);
        exp_rd  = 8'h00;
        if (!exp_err) begin
            if (w) model[which][a[5:0]] = d;
            else   exp_rd = model[which][a[5:0]];
        end
        applyStimulus(w, a, d, b2b, rd, err, n_acc);
        checkOutput({tag, "_ready"}, 32'(n_acc != 0), 32'h1);
        checkOutput({tag, "_lat"}, n_acc, which ? 32'd1 : 32'd3);
        checkOutput({tag, "_rd"}, rd, exp_rd);
        checkOutput({tag, "_err"}, err, exp_err);
    endtask

    initial begin
        logic [7:0] rd;
        bit         err;
        int         n_acc;
        bit         exp_prot;
`ifdef APB_SLV_PROT_CHK_EN
        exp_prot = 1'b1;
`else
        exp_prot = 1'b0;
`endif
        which = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

        vecs[0] = '{1'b1, 8'h10, 8'h5A, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h10, 8'h00, 1'b0, 8'h5A, 1'b0};
        vecs[2] = '{1'b1, 8'h40, 8'hFF, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 8'h40, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{1'b1, 8'h01, 8'h11, 1'b1, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 8'h01, 8'h00, 1'b0, 8'h11, 1'b0};
        vecs[6] = '{1'b1, 8'h3F, 8'hC3, 1'b1, 8'h00, 1'b0};
        vecs[7] = '{1'b0, 8'h3F, 8'h00, 1'b0, 8'hC3, 1'b0};

        doReset();
        @(negedge pclk);
        checkOutput("reset_a", {pready_a, pslverr_a, prdata_a, prot_a}, 32'h0);
        checkOutput("reset_b", {pready_b, pslverr_b, prdata_b, prot_b}, 32'h0);

        $display("[TB] prefill");
        for (int i = 0; i < 64; i++) begin
            doCheckedXfer(1'b1, 8'(i), 8'($urandom), 1'b0, "fill");
        end

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].w && !vecs[i].exp_err) model[0][vecs[i].a[5:0]] = vecs[i].d;
            applyStimulus(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b2b, rd, err, n_acc);
            checkOutput($sformatf("vec%0d_lat", i), n_acc, 32'd3);
            checkOutput($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
        end

        $display("[TB] full readback after error write");
        for (int i = 0; i < 64; i++) begin
            doCheckedXfer(1'b0, 8'(i), 8'h00, 1'b0, "rdall");
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) begin
            doCheckedXfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 79)), 8'($urandom),
                          (i == 149) ? 1'b0 : 1'($urandom_range(0, 1)), "rnd");
        end
        checkOutput("prot_clean_a", prot_a, 32'h0);

        $display("[TB] reset during access");
        doCheckedXfer(1'b1, 8'h05, 8'h33, 1'b0, "pre_abort");
        @(posedge pclk);
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h77;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        checkOutput("abort_acc1", pready, 32'h0);
        @(posedge pclk);
        #1 presetn = 1'b0;
        @(negedge pclk);
        checkOutput("abort_acc2", pready, 32'h0);
        @(posedge pclk);
        #1 presetn = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        checkOutput("abort_idle", {pready, pslverr, prdata, prot_a}, 32'h0);
        doCheckedXfer(1'b0, 8'h05, 8'h00, 1'b0, "post_abort");

        $display("[TB] enable without setup");
        @(posedge pclk);
        #1 psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h02;
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        checkOutput("prot_set", prot_a, 32'(exp_prot));
        checkOutput("prot_no_ready", pready, 32'h0);
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        checkOutput("prot_hold", prot_a, 32'(exp_prot));
        doReset();
        @(negedge pclk);
        checkOutput("prot_cleared", prot_a, 32'h0);
        doCheckedXfer(1'b0, 8'h01, 8'h00, 1'b0, "after_prot");

        $display("[TB] zero wait states");
        which = 1'b1;
        doCheckedXfer(1'b1, 8'h3F, 8'hA5, 1'b0, "ws0_wr");
        doCheckedXfer(1'b0, 8'h3F, 8'h00, 1'b0, "ws0_rd");
        doCheckedXfer(1'b1, 8'h01, 8'h11, 1'b1, "ws0_b2b_wr");
        doCheckedXfer(1'b0, 8'h01, 8'h00, 1'b0, "ws0_b2b_rd");
        doCheckedXfer(1'b0, 8'h40, 8'h00, 1'b0, "ws0_err");
        checkOutput("prot_clean_b", prot_b, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
